block_lock_fsm: RTL and testbench

BLOCK_LOCK_FSM -- requirements
Module: block_lock_fsm

---
 rtl/block_lock_fsm.sv | 172 +++++++++++++++++
 tb/tb_block_lock_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/block_lock_fsm.sv
// -----------------------------------------------------------------------------
// block_lock_fsm
//
// 64b/66b block-lock state machine. Watches the 2-bit sync header of each
// received block and decides whether the gearbox is aligned to block
// boundaries. While unaligned, every invalid header requests a one-bit slip.
// Once aligned, lock is only dropped when too many invalid headers appear
// within one test window.
//
// Ports:
//   i_clk            in   1  single clock, rising edge
//   i_reset          in   1  asynchronous, active-high reset
//   i_sync_hdr       in   2  sync header from the gearbox block-sync stage
//   i_sync_hdr_valid in   1  qualifies i_sync_hdr, one cycle per 66b block
//   o_slip           out  1  registered one-cycle slip request to the gearbox
//   o_block_lock     out  1  registered block-alignment indication
//   o_state          out  2  current state register, for debug
//
// Optional feature (macro BLOCK_LOCK_STATS_EN):
//   o_slip_count     out 16  number of SLIP cycles, saturating at 16'hFFFF
//   o_lock_loss      out  1  one-cycle pulse when o_block_lock falls
// -----------------------------------------------------------------------------
module block_lock_fsm #(
    parameter int SH_CNT_MAX     = 64,  // headers per test window, 2..127
    parameter int SH_INVALID_MAX = 16,  // invalid headers that drop lock
    parameter int SLIP_WAIT      = 4    // idle cycles after a slip, 1..15
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_sync_hdr,
    input  logic       i_sync_hdr_valid,
    output logic       o_slip,
    output logic       o_block_lock,
    output logic [1:0] o_state
`ifdef BLOCK_LOCK_STATS_EN
    ,
    output logic [15:0] o_slip_count,
    output logic        o_lock_loss
`endif
);

    typedef enum logic [1:0] {
        ST_LOCK_INIT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    localparam logic [6:0] CNT_MAX     = 7'(SH_CNT_MAX);
    localparam logic [4:0] INVALID_MAX = 5'(SH_INVALID_MAX);
    localparam logic [3:0] WAIT_LOAD   = 4'(SLIP_WAIT);

    state_t     state, state_next;
    logic [6:0] sh_cnt, sh_cnt_next;
    logic [4:0] sh_invalid_cnt, sh_invalid_cnt_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       lock_next;
    logic       hdr_bad;
    logic [6:0] cnt_inc;
    logic [4:0] invalid_inc;

    // 01 and 10 are the only legal sync headers.
    assign hdr_bad     = (i_sync_hdr == 2'b00) || (i_sync_hdr == 2'b11);
    assign cnt_inc     = sh_cnt + 7'd1;
    assign invalid_inc = sh_invalid_cnt + 5'(hdr_bad);

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_next          = state;
        sh_cnt_next         = sh_cnt;
        sh_invalid_cnt_next = sh_invalid_cnt;
        wait_cnt_next       = wait_cnt;
        lock_next           = o_block_lock;

        case (state)
            ST_LOCK_INIT: begin
                sh_cnt_next         = '0;
                sh_invalid_cnt_next = '0;
                lock_next           = 1'b0;
                state_next          = ST_TEST_SH;
            end

            ST_TEST_SH: begin
                if (i_sync_hdr_valid) begin
                    if (!hdr_bad) begin
                        if (cnt_inc == CNT_MAX) begin
                            // A clean window acquires lock; a window with
                            // errors (only possible while locked) keeps it.
                            if (sh_invalid_cnt == '0)
                                lock_next = 1'b1;
                            sh_cnt_next         = '0;
                            sh_invalid_cnt_next = '0;
                        end else begin
                            sh_cnt_next = cnt_inc;
                        end
                    end else if (!o_block_lock || invalid_inc == INVALID_MAX) begin
                        // Lock drops on the same edge the slip is raised.
                        state_next          = ST_SLIP;
                        lock_next           = 1'b0;
                        sh_cnt_next         = cnt_inc;
                        sh_invalid_cnt_next = invalid_inc;
                    end else if (cnt_inc == CNT_MAX) begin
                        sh_cnt_next         = '0;
                        sh_invalid_cnt_next = '0;
                    end else begin
                        sh_cnt_next         = cnt_inc;
                        sh_invalid_cnt_next = invalid_inc;
                    end
                end
            end

            ST_SLIP: begin
                lock_next     = 1'b0;
                wait_cnt_next = WAIT_LOAD;
                state_next    = ST_SLIP_WAIT;
            end

            ST_SLIP_WAIT: begin
                // Headers are ignored here while the gearbox settles.
                if (wait_cnt == '0) begin
                    sh_cnt_next         = '0;
                    sh_invalid_cnt_next = '0;
                    state_next          = ST_TEST_SH;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end

            default: state_next = ST_LOCK_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_LOCK_INIT;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            wait_cnt       <= '0;
            o_slip         <= 1'b0;
            o_block_lock   <= 1'b0;
        end else begin
            state          <= state_next;
            sh_cnt         <= sh_cnt_next;
            sh_invalid_cnt <= sh_invalid_cnt_next;
            wait_cnt       <= wait_cnt_next;
            // Registered from the next state, so o_slip is high exactly
            // while the state register holds SLIP.
            o_slip         <= (state_next == ST_SLIP);
            o_block_lock   <= lock_next;
        end
    end

    assign o_state = state;

`ifdef BLOCK_LOCK_STATS_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_slip_count <= '0;
            o_lock_loss  <= 1'b0;
        end else begin
            if (state == ST_SLIP && o_slip_count != 16'hFFFF)
                o_slip_count <= o_slip_count + 16'd1;
            // Aligned with the falling edge of the registered lock output.
            o_lock_loss <= o_block_lock & ~lock_next;
        end
    end
`endif

endmodule

// File: tb/tb_block_lock_fsm.sv
// -----------------------------------------------------------------------------
// tb_block_lock_fsm
//
// Directed testbench for block_lock_fsm with default parameters
// (64-header window, 16 invalid headers drop lock, 4-cycle slip wait).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_lock_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] sync_hdr;
    logic       sync_hdr_valid;
    logic       slip;
    logic       block_lock;
    logic [1:0] state;
`ifdef BLOCK_LOCK_STATS_EN
    logic [15:0] slip_count;
    logic        lock_loss;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int slip_total = 0;
    int slip_consec = 0;
    logic slip_prev = 1'b0;

    block_lock_fsm dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_sync_hdr       (sync_hdr),
        .i_sync_hdr_valid (sync_hdr_valid),
        .o_slip           (slip),
        .o_block_lock     (block_lock),
        .o_state          (state)
`ifdef BLOCK_LOCK_STATS_EN
        ,
        .o_slip_count     (slip_count),
        .o_lock_loss      (lock_loss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts slip pulses and any back-to-back slip cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (slip) slip_total++;
            if (slip && slip_prev) slip_consec++;
            slip_prev = slip;
        end else begin
            slip_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] h, input logic v);
        sync_hdr       = h;
        sync_hdr_valid = v;
        tick();
    endtask

    function automatic logic [1:0] alt_hdr(input int i);
        return (i % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    // 64 good headers, one every second cycle; lock must rise exactly
    // after the 64th and not before.
    task automatic acquire_lock(input string tag);
        for (int i = 0; i < 64; i++) begin
            drive(alt_hdr(i), 1'b1);
            if (i == 62) check({tag, "_lock_after_63"}, int'(block_lock), 0);
            if (i == 63) begin
                check({tag, "_lock_after_64"}, int'(block_lock), 1);
                check({tag, "_state"}, int'(state), 1);
            end
            drive(2'b00, 1'b0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        sync_hdr       = 2'b00;
        sync_hdr_valid = 1'b0;

        // Reset state, before any clock edge.
        #3;
        check("rst_state", int'(state), 0);
        check("rst_slip", int'(slip), 0);
        check("rst_lock", int'(block_lock), 0);

        tick();
        tick();
        rst = 1'b0;
        check("init_state", int'(state), 0);
        tick();
        check("first_test_sh", int'(state), 1);

        // Acquire lock from reset.
        acquire_lock("w1");
        check("w1_no_slip", slip_total, 0);

        // Garbage header without valid must be ignored.
        repeat (6) drive(2'b00, 1'b0);
        check("novalid_state", int'(state), 1);
        check("novalid_lock", int'(block_lock), 1);
        check("novalid_slip", slip_total, 0);

        // Window with 15 invalid headers, the last one ending the window.
        for (int i = 0; i < 64; i++) begin
            drive((i < 49) ? alt_hdr(i) : 2'b11, 1'b1);
            drive(2'b00, 1'b0);
        end
        check("w2_lock_held", int'(block_lock), 1);
        check("w2_state", int'(state), 1);
        check("w2_no_slip", slip_total, 0);

        // Fresh window: 15 invalid keep lock, the 16th drops it.
        for (int i = 0; i < 15; i++) begin
            drive(2'b11, 1'b1);
            drive(2'b00, 1'b0);
        end
        check("w3_15_lock", int'(block_lock), 1);
        check("w3_15_state", int'(state), 1);
        drive(2'b11, 1'b1);
        check("w3_16_lock", int'(block_lock), 0);
        check("w3_16_slip", int'(slip), 1);
        check("w3_16_state", int'(state), 2);
`ifdef BLOCK_LOCK_STATS_EN
        check("w3_lock_loss", int'(lock_loss), 1);
`endif

        // Invalid headers keep arriving but SLIP_WAIT ignores them.
        tick();
        check("sw_enter_state", int'(state), 3);
        check("sw_enter_slip", int'(slip), 0);
`ifdef BLOCK_LOCK_STATS_EN
        check("sw_slip_count", int'(slip_count), 1);
        check("sw_lock_loss", int'(lock_loss), 0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sw_hold_%0d", i), int'(state), 3);
        end
        tick();
        check("sw_exit_state", int'(state), 1);
        check("sw_exit_slip", int'(slip), 0);
        sync_hdr_valid = 1'b0;
        sync_hdr       = 2'b00;

        // Counting restarts from zero after the wait.
        acquire_lock("w4");

        // Asynchronous reset while locked.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rl_state", int'(state), 0);
        check("rl_lock", int'(block_lock), 0);
        check("rl_slip", int'(slip), 0);
        tick();
        rst = 1'b0;
        check("rl_release_state", int'(state), 0);
        tick();
        check("rl_test_sh", int'(state), 1);
        check("rl_lock_after", int'(block_lock), 0);

        // Unlocked invalid header slips immediately.
        drive(2'b11, 1'b1);
        check("ul_slip", int'(slip), 1);
        check("ul_state", int'(state), 2);
        drive(2'b00, 1'b0);
        check("ul_slip_once", int'(slip), 0);
        check("ul_wait", int'(state), 3);
        drive(2'b00, 1'b0);

        // Asynchronous reset in the middle of SLIP_WAIT.
        #2;
        rst = 1'b1;
        #1;
        check("rw_state", int'(state), 0);
        check("rw_slip", int'(slip), 0);
        check("rw_lock", int'(block_lock), 0);
        tick();
        rst = 1'b0;
        check("rw_release_state", int'(state), 0);
        tick();
        check("rw_test_sh", int'(state), 1);
        repeat (8) drive(2'b00, 1'b0);
        check("rw_state_idle", int'(state), 1);
        check("slip_total", slip_total, 2);
        check("slip_consecutive", slip_consec, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
